// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/ack data bus with lane steering, load extension and a watchdog.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring the low address bits.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead_mem,
    input  logic        MEM_MemWrite_mem,
    input  logic [1:0]  MemSize_mem,
    input  logic        MemSigned_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MemReadData_mem,
    output logic        mem_stall,
    output logic        mem_fault
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  wd;
    logic [1:0]  off, size_r;
    logic        signed_r, load_r;
    logic        pending, misalign, timeout;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx, load_val;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign pending = MEM_MemRead_mem | MEM_MemWrite_mem;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (MemSize_mem == 2'b01) ? ALUResult_mem[0] :
                      MemSize_mem[1] ? |ALUResult_mem[1:0] : 1'b0;
`else
    assign misalign = 1'b0;
`endif
    assign be_nx = (MemSize_mem == 2'b00) ? 4'b0001 << ALUResult_mem[1:0] :
                   (MemSize_mem == 2'b01) ? (ALUResult_mem[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_nx = (MemSize_mem == 2'b00) ? {4{MemWriteData_mem[7:0]}} :
                      (MemSize_mem == 2'b01) ? {2{MemWriteData_mem[15:0]}} : MemWriteData_mem;
    assign rbyte = dmem_rdata[{off, 3'b000} +: 8];
    assign rhalf = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign load_val = (size_r == 2'b00) ? {{24{signed_r & rbyte[7]}}, rbyte} :
                      (size_r == 2'b01) ? {{16{signed_r & rhalf[15]}}, rhalf} : dmem_rdata;
    // counter hits 15 on this edge without an ack
    assign timeout = (wd == 4'd14) && !dmem_ack;
    assign mem_stall = (state == WAIT) || (state == IDLE && pending);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (pending) begin
                if (misalign) state_nx = DONE;
                else state_nx = WAIT;
            end
            WAIT: if (dmem_ack || timeout) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= '0;
            MemReadData_mem <= '0;
            mem_fault       <= 1'b0;
            wd              <= '0;
            off             <= '0;
            size_r          <= '0;
            signed_r        <= 1'b0;
            load_r          <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_fault <= 1'b0;
            case (state)
                IDLE: if (pending) begin
                    dmem_addr <= {ALUResult_mem[31:2], 2'b00};
                    off       <= ALUResult_mem[1:0];
                    size_r    <= MemSize_mem;
                    signed_r  <= MemSigned_mem;
                    load_r    <= !MEM_MemWrite_mem;
                    wd        <= '0;
                    if (misalign) begin
                        mem_fault <= 1'b1;
                        if (!MEM_MemWrite_mem) MemReadData_mem <= '0;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MemWrite_mem;
                        dmem_be    <= be_nx;
                        dmem_wdata <= wdata_nx;
                    end
                end
                WAIT: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    if (load_r) MemReadData_mem <= load_val;
                end else if (timeout) begin
                    dmem_req        <= 1'b0;
                    mem_fault       <= 1'b1;
                    MemReadData_mem <= '0;
                end else begin
                    wd <= wd + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
